// File: rtl/dmem_responder_if.sv
// Initiator/responder bus for the wait-stated data memory responder.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, be, input ack, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-enabled stores, fixed wait states and
// a one-cycle ack/err response.
//
// state | meaning
// IDLE  | waiting for req; latches the request when it arrives
// WAIT  | counting down wait states; access happens on the edge leaving WAIT
// RESP  | ack high for one cycle with registered rdata/err
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           cur_word;
  logic [31:0]           merged;
  logic                  fault;
  logic                  access;

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign cur_word = mem[idx];
  assign fault    = (|addr_q[1:0]) | (|addr_q[31:DEPTH_LOG2+2]);
  assign access   = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (access) begin
        err_q   <= fault;
        rdata_q <= fault ? 32'd0 : (we_q ? merged : cur_word);
      end else if (state == RESP) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Request capture and storage are deliberately not reset; reset can only
  // discard a pending store by forcing the FSM out of WAIT.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      we_q    <= bus.we;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
      be_q    <= bus.be;
    end
    if (access && we_q && !fault) mem[idx] <= merged;
  end

  assign bus.ack   = (state == RESP);
  assign bus.busy  = (state != IDLE);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for most
// scenarios and a WAIT_CYCLES=0 instance for the zero-wait latency.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One access on the WAIT_CYCLES=2 instance. Entered just after an edge with
  // the DUT idle; ack must be seen after edge k+3 (k = sampling edge).
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic e);
    int lat;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = ~w; bus.addr = ~a; bus.wdata = ~d; bus.be = ~b;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
      n_bad++;
      $display("FAIL access_wait addr=%h: busy=%b ack=%b, want busy=1 ack=0", a, bus.busy, bus.ack);
    end
    lat = 0;
    while (bus.ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != 3) begin
      n_bad++;
      $display("FAIL access_latency addr=%h: ack after %0d edges, want 3", a, lat);
    end
    rd = bus.rdata;
    e  = bus.err;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.ack, bus.busy, bus.err, bus.rdata} !== 35'd0) begin
      n_bad++;
      $display("FAIL access_release addr=%h: ack=%b busy=%b err=%b rdata=%h, want all 0",
               a, bus.ack, bus.busy, bus.err, bus.rdata);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.ack, bus.busy, bus.err, bus.rdata, bus0.ack, bus0.busy, bus0.err, bus0.rdata} !== 70'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: ack=%b busy=%b err=%b rdata=%h, want all 0",
               bus.ack, bus.busy, bus.err, bus.rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        e;
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_bad++; $display("FAIL store_full: rdata=%h err=%b, want deadbeef/0", rd, e);
    end
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_bad++; $display("FAIL load_full: rdata=%h err=%b, want deadbeef/0", rd, e);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd;
    logic        e;
    access(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e);
    access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e);
    n_cmp++;
    if (rd !== 32'h11BB33DD || e !== 1'b0) begin
      n_bad++; $display("FAIL store_be0101: rdata=%h err=%b, want 11bb33dd/0", rd, e);
    end
    access(1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    n_cmp++;
    if (rd !== 32'h11BB33DD || e !== 1'b0) begin
      n_bad++; $display("FAIL load_be0101: rdata=%h err=%b, want 11bb33dd/0", rd, e);
    end
  endtask

  task automatic test_be_zero();
    logic [31:0] rd;
    logic        e;
    access(1'b1, 32'h10, 32'h01234567, 4'h0, rd, e);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_bad++; $display("FAIL store_be0: rdata=%h err=%b, want deadbeef/0", rd, e);
    end
    access(1'b0, 32'h10, 32'h0, 4'hF, rd, e);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL load_after_be0: rdata=%h, want deadbeef", rd);
    end
  endtask

  task automatic test_fault();
    logic [31:0] rd;
    logic        e;
    access(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, e);
    access(1'b0, 32'h2, 32'h0, 4'h0, rd, e);
    n_cmp++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      n_bad++; $display("FAIL fault_misaligned_load: rdata=%h err=%b, want 0/1", rd, e);
    end
    access(1'b1, 32'h100, 32'h55555555, 4'hF, rd, e);
    n_cmp++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      n_bad++; $display("FAIL fault_range_store: rdata=%h err=%b, want 0/1", rd, e);
    end
    access(1'b1, 32'h1, 32'h77777777, 4'hF, rd, e);
    n_cmp++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      n_bad++; $display("FAIL fault_misaligned_store: rdata=%h err=%b, want 0/1", rd, e);
    end
    access(1'b0, 32'h0, 32'h0, 4'h0, rd, e);
    n_cmp++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
      n_bad++; $display("FAIL fault_word0_intact: rdata=%h err=%b, want cafef00d/0", rd, e);
    end
  endtask

  // req held high: each access spans 5 cycles (3 WAIT, 1 RESP, 1 IDLE).
  task automatic test_back_to_back();
    int acks;
    acks = 0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.be = 4'h0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) begin
        acks++;
        n_cmp++;
        if (bus.rdata !== 32'hDEADBEEF) begin
          n_bad++; $display("FAIL b2b_rdata cycle %0d: rdata=%h, want deadbeef", i, bus.rdata);
        end
      end
      n_cmp++;
      if (bus.busy !== (i % 5 != 4) || bus.ack !== (i % 5 == 3)) begin
        n_bad++;
        $display("FAIL b2b_pattern cycle %0d: busy=%b ack=%b, want busy=%b ack=%b",
                 i, bus.busy, bus.ack, (i % 5 != 4), (i % 5 == 3));
      end
      if (i == 14) bus.req = 1'b0;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (acks != 3 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_count: acks=%0d busy=%b, want 3/0", acks, bus.busy);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    logic        e;
    int          acks;
    access(1'b1, 32'h30, 32'h55, 4'hF, rd, e);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h30; bus.wdata = 32'h99; bus.be = 4'hF;
    @(posedge clk); #1;
    bus.req = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_wait_entry: busy=%b, want 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
      n_bad++; $display("FAIL rst_async: busy=%b ack=%b, want 0/0", bus.busy, bus.ack);
    end
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) acks++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_bad++; $display("FAIL rst_no_ack: acks=%0d, want 0", acks);
    end
    access(1'b0, 32'h30, 32'h0, 4'h0, rd, e);
    n_cmp++;
    if (rd !== 32'h55 || e !== 1'b0) begin
      n_bad++; $display("FAIL rst_discard_store: rdata=%h err=%b, want 00000055/0", rd, e);
    end
  endtask

  task automatic test_zero_wait();
    logic        we_v  [2];
    logic [31:0] exp_v [2];
    we_v[0] = 1'b1; we_v[1] = 1'b0;
    exp_v[0] = 32'h12345678; exp_v[1] = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      bus0.req = 1'b1; bus0.we = we_v[i]; bus0.addr = 32'h4;
      bus0.wdata = 32'h12345678; bus0.be = 4'hF;
      @(posedge clk); #1;
      bus0.req = 1'b0; bus0.wdata = 32'hFFFFFFFF;
      n_cmp++;
      if (bus0.ack !== 1'b0 || bus0.busy !== 1'b1) begin
        n_bad++; $display("FAIL zw_wait op%0d: ack=%b busy=%b, want 0/1", i, bus0.ack, bus0.busy);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus0.ack !== 1'b1 || bus0.rdata !== exp_v[i] || bus0.err !== 1'b0) begin
        n_bad++;
        $display("FAIL zw_resp op%0d: ack=%b rdata=%h err=%b, want 1/%h/0",
                 i, bus0.ack, bus0.rdata, bus0.err, exp_v[i]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin
        n_bad++; $display("FAIL zw_idle op%0d: ack=%b busy=%b, want 0/0", i, bus0.ack, bus0.busy);
      end
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.be = 4'h0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0; bus0.be = 4'h0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_be_zero();
    test_fault();
    test_back_to_back();
    test_reset_in_wait();
    test_zero_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
